serial_word_assembler: RTL and testbench

- Serial-to-parallel front end. Accepts one data bit per cycle over a valid/ready handshake, plus an optional trailing parity bit.
- Assembles N bits LSB-first into a right-shifting register; the newest bit enters at the MSB.
- Presents the completed word and a parity-error flag over a valid/ready handshake.
- Sits directly upstream of the datapath's parallel-load registers. Its word_out feeds their din, and its word_valid/word_ready pair gates their ld.

---
 rtl/serial_word_assembler.sv | 103 ++++++++++
 tb/tb_serial_word_assembler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler: collects N bits LSB-first (plus an optional
// parity bit) and hands the finished word downstream over a valid/ready pair.
module serial_word_assembler #(
  parameter int N          = 32,
  parameter int PARITY_EN  = 0,
  parameter int ODD_PARITY = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  output logic                   bit_ready,
  output logic [N-1:0]           word_out,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic                   par_err,
  output logic [$clog2(N):0]     bit_cnt
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    COLLECT,
    PARITY,
    HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            perr_q, perr_d;
  logic            parity_expected;

  assign parity_expected = (^sr_q) ^ (ODD_PARITY != 0);

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    perr_d     = perr_q;
    bit_ready  = 1'b0;
    word_valid = 1'b0;

    case (state_q)
      COLLECT: begin
        bit_ready = 1'b1;
        if (bit_valid) begin
          sr_d  = {bit_in, sr_q[N-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            state_d = (PARITY_EN != 0) ? PARITY : HOLD;
          end
        end
      end
      PARITY: begin
        bit_ready = 1'b1;
        if (bit_valid) begin
          perr_d  = (bit_in != parity_expected);
          state_d = HOLD;
        end
      end
      HOLD: begin
        word_valid = 1'b1;
        if (word_ready) begin
          state_d = COLLECT;
          cnt_d   = '0;
          perr_d  = 1'b0;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase

    // Clear wins over any bit or word transfer; a held word is simply dropped.
    if (clr) begin
      state_d = COLLECT;
      sr_d    = '0;
      cnt_d   = '0;
      perr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= COLLECT;
      sr_q    <= '0;
      cnt_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
    end
  end

  assign word_out = sr_q;
  assign bit_cnt  = cnt_q;
  assign par_err  = (PARITY_EN != 0) && perr_q;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Self-checking bench for serial_word_assembler: three N=8 instances
// (no parity, even parity, odd parity) with a scoreboard of expected words.
module tb_serial_word_assembler;

  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[3];
  logic       clr[3];
  logic       bit_in[3];
  logic       bit_valid[3];
  logic       word_ready[3];
  logic       bit_ready[3];
  logic       word_valid[3];
  logic       par_err[3];
  logic [7:0] word_out[3];
  logic [3:0] bit_cnt[3];

  // Scoreboard entries are {expected par_err, expected word}.
  logic [8:0] sb_q[$];
  logic [8:0] exp_e;
  int checks = 0;
  int passes = 0;

  serial_word_assembler #(.N(N), .PARITY_EN(0), .ODD_PARITY(0)) dut_np (
    .clk(clk), .rst(rst[0]), .clr(clr[0]), .bit_in(bit_in[0]), .bit_valid(bit_valid[0]),
    .bit_ready(bit_ready[0]), .word_out(word_out[0]), .word_valid(word_valid[0]),
    .word_ready(word_ready[0]), .par_err(par_err[0]), .bit_cnt(bit_cnt[0]));

  serial_word_assembler #(.N(N), .PARITY_EN(1), .ODD_PARITY(0)) dut_even (
    .clk(clk), .rst(rst[1]), .clr(clr[1]), .bit_in(bit_in[1]), .bit_valid(bit_valid[1]),
    .bit_ready(bit_ready[1]), .word_out(word_out[1]), .word_valid(word_valid[1]),
    .word_ready(word_ready[1]), .par_err(par_err[1]), .bit_cnt(bit_cnt[1]));

  serial_word_assembler #(.N(N), .PARITY_EN(1), .ODD_PARITY(1)) dut_odd (
    .clk(clk), .rst(rst[2]), .clr(clr[2]), .bit_in(bit_in[2]), .bit_valid(bit_valid[2]),
    .bit_ready(bit_ready[2]), .word_out(word_out[2]), .word_valid(word_valid[2]),
    .word_ready(word_ready[2]), .par_err(par_err[2]), .bit_cnt(bit_cnt[2]));

  task automatic send_bit(input int d, input logic b);
    bit_in[d]    = b;
    bit_valid[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bit_valid[d] = 1'b0;
  endtask

  // Drives a full word (plus parity bit on the parity instances) and records
  // what the DUT should present once it holds the word.
  task automatic send_word(input int d, input logic [7:0] w, input logic pbit,
                           input logic eperr);
    for (int i = 0; i < N; i++) send_bit(d, w[i]);
    if (d != 0) send_bit(d, pbit);
    sb_q.push_back({eperr, w});
  endtask

  task automatic take_word(input int d);
    word_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    word_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (word_out[d] !== 8'h00 || bit_cnt[d] !== 4'd0 || word_valid[d] !== 1'b0 ||
          bit_ready[d] !== 1'b1 || par_err[d] !== 1'b0)
        $display("[TB] FAIL reset_state dut%0d: wo=%h cnt=%0d wv=%b br=%b pe=%b, want 00/0/0/1/0",
                 d, word_out[d], bit_cnt[d], word_valid[d], bit_ready[d], par_err[d]);
      else passes++;
    end
  endtask

  task automatic test_basic();
    send_word(0, 8'hA5, 1'b0, 1'b0);
    exp_e = sb_q.pop_front();
    checks++;
    if (word_valid[0] !== 1'b1 || word_out[0] !== exp_e[7:0] || bit_ready[0] !== 1'b0 ||
        bit_cnt[0] !== 4'd8)
      $display("[TB] FAIL basic_hold: wv=%b wo=%h br=%b cnt=%0d, want 1/%h/0/8",
               word_valid[0], word_out[0], bit_ready[0], bit_cnt[0], exp_e[7:0]);
    else passes++;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      bit_in[0]    = i[0];
      bit_valid[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    bit_valid[0] = 1'b0;
    checks++;
    if (word_valid[0] !== 1'b1 || word_out[0] !== 8'hA5 || bit_cnt[0] !== 4'd8)
      $display("[TB] FAIL backpressure_stable: wv=%b wo=%h cnt=%0d, want 1/a5/8",
               word_valid[0], word_out[0], bit_cnt[0]);
    else passes++;
  endtask

  task automatic test_back_to_back();
    // The bit offered during the word transfer must not be consumed.
    word_ready[0] = 1'b1;
    bit_in[0]     = 1'b1;
    bit_valid[0]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    word_ready[0] = 1'b0;
    bit_valid[0]  = 1'b0;
    checks++;
    if (word_valid[0] !== 1'b0 || bit_cnt[0] !== 4'd0 || bit_ready[0] !== 1'b1)
      $display("[TB] FAIL word_transfer: wv=%b cnt=%0d br=%b, want 0/0/1",
               word_valid[0], bit_cnt[0], bit_ready[0]);
    else passes++;
    send_word(0, 8'h3C, 1'b0, 1'b0);
    exp_e = sb_q.pop_front();
    checks++;
    if (word_valid[0] !== 1'b1 || word_out[0] !== exp_e[7:0])
      $display("[TB] FAIL back_to_back_word: wv=%b wo=%h, want 1/%h",
               word_valid[0], word_out[0], exp_e[7:0]);
    else passes++;
    take_word(0);
  endtask

  task automatic test_parity();
    int d;
    logic [7:0] words[4] = '{8'hA5, 8'h07, 8'h07, 8'hA5};
    logic       pbits[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic       perrs[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      d = (k < 2) ? 1 : 2;
      for (int i = 0; i < N; i++) send_bit(d, words[k][i]);
      checks++;
      if (word_valid[d] !== 1'b0 || bit_ready[d] !== 1'b1 || bit_cnt[d] !== 4'd8)
        $display("[TB] FAIL parity_phase%0d: wv=%b br=%b cnt=%0d, want 0/1/8",
                 k, word_valid[d], bit_ready[d], bit_cnt[d]);
      else passes++;
      send_bit(d, pbits[k]);
      sb_q.push_back({perrs[k], words[k]});
      exp_e = sb_q.pop_front();
      checks++;
      if (word_valid[d] !== 1'b1 || word_out[d] !== exp_e[7:0] || par_err[d] !== exp_e[8])
        $display("[TB] FAIL parity_word%0d: wv=%b wo=%h pe=%b, want 1/%h/%b",
                 k, word_valid[d], word_out[d], par_err[d], exp_e[7:0], exp_e[8]);
      else passes++;
      take_word(d);
      checks++;
      if (word_valid[d] !== 1'b0 || par_err[d] !== 1'b0)
        $display("[TB] FAIL parity_release%0d: wv=%b pe=%b, want 0/0",
                 k, word_valid[d], par_err[d]);
      else passes++;
    end
  endtask

  task automatic test_gaps();
    logic [7:0] w = 8'h0F;
    int         n;
    for (int i = 0; i < N; i++) begin
      send_bit(0, w[i]);
      repeat (2) begin
        bit_in[0] = ~bit_in[0];
        @(posedge clk);
        @(negedge clk);
      end
      checks++;
      if (bit_cnt[0] !== 4'(i + 1))
        $display("[TB] FAIL gap_count%0d: cnt=%0d, want %0d", i, bit_cnt[0], i + 1);
      else passes++;
    end
    sb_q.push_back({1'b0, w});
    n = 0;
    while (word_valid[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    exp_e = sb_q.pop_front();
    checks++;
    if (word_valid[0] !== 1'b1 || word_out[0] !== exp_e[7:0])
      $display("[TB] FAIL gap_word: wv=%b wo=%h, want 1/%h", word_valid[0], word_out[0],
               exp_e[7:0]);
    else passes++;
    take_word(0);
  endtask

  task automatic test_clr();
    for (int i = 0; i < 5; i++) send_bit(0, 1'b1);
    clr[0]       = 1'b1;
    bit_in[0]    = 1'b1;
    bit_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr[0]       = 1'b0;
    bit_valid[0] = 1'b0;
    checks++;
    if (bit_cnt[0] !== 4'd0 || word_out[0] !== 8'h00 || bit_ready[0] !== 1'b1)
      $display("[TB] FAIL clr_midword: cnt=%0d wo=%h br=%b, want 0/00/1",
               bit_cnt[0], word_out[0], bit_ready[0]);
    else passes++;

    send_word(1, 8'hA5, 1'b1, 1'b1);
    exp_e = sb_q.pop_front();
    checks++;
    if (word_valid[1] !== 1'b1 || par_err[1] !== exp_e[8] || word_out[1] !== exp_e[7:0])
      $display("[TB] FAIL clr_setup: wv=%b pe=%b wo=%h, want 1/%b/%h",
               word_valid[1], par_err[1], word_out[1], exp_e[8], exp_e[7:0]);
    else passes++;
    clr[1]        = 1'b1;
    word_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr[1]        = 1'b0;
    word_ready[1] = 1'b0;
    checks++;
    if (word_valid[1] !== 1'b0 || par_err[1] !== 1'b0 || word_out[1] !== 8'h00 ||
        bit_cnt[1] !== 4'd0)
      $display("[TB] FAIL clr_hold: wv=%b pe=%b wo=%h cnt=%0d, want 0/0/00/0",
               word_valid[1], par_err[1], word_out[1], bit_cnt[1]);
    else passes++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
    #2;
    rst[0] = 1'b0;
    #1;
    checks++;
    if (bit_cnt[0] !== 4'd0 || word_out[0] !== 8'h00 || word_valid[0] !== 1'b0 ||
        bit_ready[0] !== 1'b1 || par_err[0] !== 1'b0)
      $display("[TB] FAIL async_reset: cnt=%0d wo=%h wv=%b br=%b pe=%b, want 0/00/0/1/0",
               bit_cnt[0], word_out[0], word_valid[0], bit_ready[0], par_err[0]);
    else passes++;
    @(negedge clk);
    rst[0] = 1'b1;
    send_word(0, 8'h5A, 1'b0, 1'b0);
    exp_e = sb_q.pop_front();
    checks++;
    if (word_valid[0] !== 1'b1 || word_out[0] !== exp_e[7:0] || bit_cnt[0] !== 4'd8)
      $display("[TB] FAIL after_reset_word: wv=%b wo=%h cnt=%0d, want 1/%h/8",
               word_valid[0], word_out[0], bit_cnt[0], exp_e[7:0]);
    else passes++;
    take_word(0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d]        = 1'b0;
      clr[d]        = 1'b0;
      bit_in[d]     = 1'b0;
      bit_valid[d]  = 1'b0;
      word_ready[d] = 1'b0;
    end
    #12;
    test_reset();
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b1;
    @(negedge clk);

    test_basic();
    test_backpressure();
    test_back_to_back();
    test_parity();
    test_gaps();
    test_clr();
    test_async_reset();

    checks++;
    if (sb_q.size() != 0)
      $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    else passes++;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
